// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single Common Data Bus between NUM_REQ functional-unit completion
// ports. Each port owns a one-entry holding slot. One slot per cycle is granted
// and broadcast on the registered CDB (tag, value). A squash flushes every
// pending completion.
//
// Optional feature, selected by macro CDB_AGE_PRIORITY_EN:
//   defined   - the oldest pending tag relative to rob_head_tag wins. Ties go to
//               the lowest index. The design falls back to round-robin while
//               rob_head_tag == 0 (ROB empty).
//   undefined - pure round-robin. rob_head_tag is ignored.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   req_valid     per-FU completed result present
//   req_tag       per-FU ROB tag, slice i = [i*TAG_W +: TAG_W]
//   req_value     per-FU result value, slice i = [i*DATA_W +: DATA_W]
//   req_ready     per-FU slot can accept this cycle
//   rob_head_tag  ROB head tag (age-priority build only)
//   squash_valid  misprediction flush
//   cdb_valid     registered broadcast valid
//   cdb_tag       registered broadcast tag
//   cdb_value     registered broadcast value
//   grant_idx     registered index of the last granted FU (debug)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_DEPTH = 9,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [TAG_W-1:0]            rob_head_tag,
  input  logic                        squash_valid,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_value,
  output logic [IDX_W-1:0]            grant_idx
);

  logic [NUM_REQ-1:0] slot_valid;
  logic [TAG_W-1:0]   slot_tag   [NUM_REQ];
  logic [DATA_W-1:0]  slot_value [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;

  logic               rr_any;
  logic [IDX_W-1:0]   rr_sel;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_sel;
  logic [NUM_REQ-1:0] grant;

  // Round-robin: scan upward from rr_ptr with wraparound, first valid slot wins.
  always_comb begin
    rr_any = 1'b0;
    rr_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!rr_any && slot_valid[j]) begin
        rr_any = 1'b1;
        rr_sel = IDX_W'(j);
      end
    end
  end

`ifdef CDB_AGE_PRIORITY_EN
  localparam logic [TAG_W:0] ROB_DEPTH_W = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W:0]   slot_age [NUM_REQ];
  logic             age_any;
  logic [IDX_W-1:0] age_sel;
  logic [TAG_W:0]   best_age;

  // Distance from the ROB head. The -1 offsets on both tags cancel, so only the
  // difference is formed. The +ROB_DEPTH term keeps the value non-negative
  // before the modulo.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_age[i] = ({1'b0, slot_tag[i]} - {1'b0, rob_head_tag} + ROB_DEPTH_W)
                    % ROB_DEPTH_W;
    end
  end

  always_comb begin
    age_any  = 1'b0;
    age_sel  = '0;
    best_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (slot_valid[i] && (!age_any || slot_age[i] < best_age)) begin
        age_any  = 1'b1;
        age_sel  = IDX_W'(i);
        best_age = slot_age[i];
      end
    end
  end

  assign grant_any = (rob_head_tag != '0) ? age_any : rr_any;
  assign grant_sel = (rob_head_tag != '0) ? age_sel : rr_sel;
`else
  logic unused_age_inputs;
  assign unused_age_inputs = ^rob_head_tag ^ (ROB_DEPTH == 0);

  assign grant_any = rr_any;
  assign grant_sel = rr_sel;
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_sel] = 1'b1;
  end

  // A slot being granted this cycle can be refilled at the same edge.
  assign req_ready = squash_valid ? '0 : (~slot_valid | grant);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_tag[i]   <= '0;
        slot_value[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      grant_idx <= '0;
    end else if (squash_valid) begin
      slot_valid <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          // A zero tag is consumed but never occupies the slot.
          slot_valid[i] <= (req_tag[i*TAG_W +: TAG_W] != '0);
          slot_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
          slot_value[i] <= req_value[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (grant_any) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= slot_tag[grant_sel];
        cdb_value <= slot_value[grant_sel];
        grant_idx <= grant_sel;
        rr_ptr    <= (int'(grant_sel) == NUM_REQ - 1) ? '0 : grant_sel + IDX_W'(1);
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= '0;
        cdb_value <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*TW-1:0]   req_tag;
  logic [N*DW-1:0]   req_value;
  logic [N-1:0]      req_ready;
  logic [TW-1:0]     rob_head_tag;
  logic              squash_valid;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic [1:0]        grant_idx;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: one pending result per FU plus a rotating priority start.
  int  m_pend  [N];
  int  m_tag   [N];
  longint m_val [N];
  int  m_start;
  int  e_valid, e_tag, e_gidx;
  longint e_val;

  cdb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_value    (req_value),
    .req_ready    (req_ready),
    .rob_head_tag (rob_head_tag),
    .squash_valid (squash_valid),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .grant_idx    (grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*TW-1:0] pk_tags(input int t0, t1, t2, t3);
    return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
  endfunction

  function automatic logic [N*DW-1:0] pk_vals(input int v0, v1, v2, v3);
    return {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_tag[i] = 0; m_val[i] = 0;
    end
    m_start = 0;
    e_valid = 0; e_tag = 0; e_val = 0; e_gidx = 0;
  endtask

  // One clock cycle: drive inputs, check ready, predict and check the broadcast.
  task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                      input logic [N*DW-1:0] d, input logic sq);
    int win;
    logic [N-1:0] exp_rdy;
    @(negedge clock);
    req_valid = v; req_tag = t; req_value = d; squash_valid = sq;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_start + k) % N;
      if (win < 0 && m_pend[idx] != 0) win = idx;
    end
    for (int i = 0; i < N; i++)
      exp_rdy[i] = !sq && (m_pend[i] == 0 || win == i);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (sq) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      e_valid = 0; e_tag = 0; e_val = 0;
    end else begin
      if (win >= 0) begin
        e_valid = 1; e_tag = m_tag[win]; e_val = m_val[win]; e_gidx = win;
        m_pend[win] = 0;
        m_start = (win + 1) % N;
      end else begin
        e_valid = 0; e_tag = 0; e_val = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && exp_rdy[i]) begin
          m_tag[i]  = int'(t[i*TW +: TW]);
          m_val[i]  = longint'(d[i*DW +: DW]);
          m_pend[i] = (m_tag[i] != 0) ? 1 : 0;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    chk("cdb_tag",   64'(cdb_tag),   64'(e_tag));
    chk("cdb_value", 64'(cdb_value), 64'(e_val));
    chk("grant_idx", 64'(grant_idx), 64'(e_gidx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    model_clear();
    req_valid = '0; squash_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'hF);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '1;
    req_tag = pk_tags(1, 2, 3, 4);
    req_value = '1;
    rob_head_tag = '0;
    squash_valid = 1'b0;
    model_clear();

    // Reset held with all requests asserted.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("init_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("init_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("init_cdb_value", 64'(cdb_value), 64'd0);
    chk("init_grant_idx", 64'(grant_idx), 64'd0);
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("init_ready", 64'(req_ready), 64'hF);

    // Single requester, then rotation starts after the winner.
    step(4'b0100, pk_tags(0, 0, 3, 0), pk_vals(0, 0, 32'hDEAD, 0), 1'b0);
    step('0, '0, '0, 1'b0);
    chk("single_tag",  64'(cdb_tag),   64'd3);
    chk("single_val",  64'(cdb_value), 64'hDEAD);
    chk("single_gidx", 64'(grant_idx), 64'd2);
    step(4'b1001, pk_tags(9, 0, 0, 8), pk_vals(11, 0, 0, 22), 1'b0);
    step('0, '0, '0, 1'b0);
    chk("rr_after2", 64'(cdb_tag), 64'd8);
    step('0, '0, '0, 1'b0);
    chk("rr_wrap", 64'(cdb_tag), 64'd9);

    // Full contention from rr_ptr = 0.
    do_reset();
    step(4'b1111, pk_tags(1, 2, 3, 4), pk_vals(100, 200, 300, 400), 1'b0);
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0, 1'b0);
      chk("contention_tag", 64'(cdb_tag), 64'(k + 1));
    end

    // Back-to-back stream from FU0.
    step(4'b0001, pk_tags(5, 0, 0, 0), pk_vals(55, 0, 0, 0), 1'b0);
    step(4'b0001, pk_tags(6, 0, 0, 0), pk_vals(66, 0, 0, 0), 1'b0);
    chk("b2b_tag5", 64'(cdb_tag), 64'd5);
    step(4'b0001, pk_tags(7, 0, 0, 0), pk_vals(77, 0, 0, 0), 1'b0);
    chk("b2b_tag6", 64'(cdb_tag), 64'd6);
    step('0, '0, '0, 1'b0);
    chk("b2b_tag7", 64'(cdb_tag), 64'd7);

    // Squash with three pending slots.
    step(4'b0111, pk_tags(2, 4, 6, 0), pk_vals(2, 4, 6, 0), 1'b0);
    step(4'b1111, pk_tags(1, 1, 1, 1), pk_vals(9, 9, 9, 9), 1'b1);
    for (int k = 0; k < 3; k++) begin
      step('0, '0, '0, 1'b0);
      chk("squash_quiet", 64'(cdb_valid), 64'd0);
    end

    // Zero tag is consumed without occupying the slot.
    step(4'b0010, pk_tags(0, 0, 0, 0), pk_vals(0, 5, 0, 0), 1'b0);
    step('0, '0, '0, 1'b0);
    chk("zero_tag", 64'(cdb_valid), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N*TW-1:0] t;
      logic [N*DW-1:0] d;
      for (int i = 0; i < N; i++) begin
        t[i*TW +: TW] = 5'($urandom_range(0, 9));
        d[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      step(4'($urandom), t, d, ($urandom_range(0, 19) == 0));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
